exhaustive_stim_misr: RTL and testbench

- Self-test stage that wraps the team's combinational gate-level circuits.
- Upstream side: drives every input combination of the circuit under test (CUT), one vector at a time.
- Downstream side: samples the CUT's output bits after a programmable settle time and compresses them into a multiple-input signature register (MISR).
- Software or a bench compares the final signature against a golden value, which replaces per-vector checking.

---
 rtl/exhaustive_stim_misr.sv | 115 +++++++++++
 tb/tb_exhaustive_stim_misr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_stim_misr.sv
// rtl/exhaustive_stim_misr.sv - exhaustive CUT stimulus generator with response MISR
// Optional macro STIM_GRAY_EN drives stim in Gray order instead of binary.
module exhaustive_stim_misr #(
  parameter int               STIM_W = 15,
  parameter int               RESP_W = 5,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int               SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [RESP_W-1:0] resp,
  output logic [STIM_W-1:0] stim,
  output logic [STIM_W-1:0] vec_count,
  output logic              capture_stb,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [1:0] {IDLE, HOLD, LAST, DONE} state_t;

  localparam logic [7:0]        SETTLE_L = 8'(SETTLE);
  localparam logic [STIM_W-1:0] VEC_LAST = '1;

  state_t            state;
  logic [7:0]        settle_cnt;
  logic [SIG_W-1:0]  misr_next;
  logic [STIM_W-1:0] vec_next;

  function automatic logic [STIM_W-1:0] to_stim(input logic [STIM_W-1:0] v);
`ifdef STIM_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  always_comb begin
    misr_next = {signature[SIG_W-2:0], 1'b0}
              ^ (signature[SIG_W-1] ? POLY : '0)
              ^ SIG_W'(resp);
    vec_next  = vec_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      stim        <= '0;
      vec_count   <= '0;
      capture_stb <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      signature   <= SEED;
    end else begin
      capture_stb <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= HOLD;
            stim       <= to_stim('0);
            vec_count  <= '0;
            signature  <= SEED;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        HOLD: begin
          // abort wins over a capture on the same edge; signature is kept for debug
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            stim       <= '0;
            vec_count  <= '0;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_L) begin
            signature   <= misr_next;
            capture_stb <= 1'b1;
            settle_cnt  <= '0;
            if (vec_count == VEC_LAST) begin
              state <= LAST;
            end else begin
              vec_count <= vec_next;
              stim      <= to_stim(vec_next);
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        LAST: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            stim       <= '0;
            vec_count  <= '0;
            settle_cnt <= '0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_misr.sv
// tb/tb_exhaustive_stim_misr.sv - directed table-driven bench for exhaustive_stim_misr
module tb_exhaustive_stim_misr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total_checks = 0;
  int passed_checks = 0;

  // small DUT, SETTLE=1
  logic        s1_start, s1_abort;
  logic [4:0]  s1_resp;
  logic [1:0]  s1_stim, s1_vc;
  logic        s1_stb, s1_busy, s1_done;
  logic [15:0] s1_sig;

  // small DUT, SETTLE=0
  logic        s0_start, s0_abort;
  logic [4:0]  s0_resp;
  logic [1:0]  s0_stim, s0_vc;
  logic        s0_stb, s0_busy, s0_done;
  logic [15:0] s0_sig;

  // full default DUT
  logic        f_start, f_abort;
  logic [4:0]  f_resp;
  logic [14:0] f_stim, f_vc;
  logic        f_stb, f_busy, f_done;
  logic [15:0] f_sig;

  exhaustive_stim_misr #(.STIM_W(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort), .resp(s1_resp),
    .stim(s1_stim), .vec_count(s1_vc), .capture_stb(s1_stb), .busy(s1_busy),
    .done(s1_done), .signature(s1_sig));

  exhaustive_stim_misr #(.STIM_W(2), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(s0_start), .abort(s0_abort), .resp(s0_resp),
    .stim(s0_stim), .vec_count(s0_vc), .capture_stb(s0_stb), .busy(s0_busy),
    .done(s0_done), .signature(s0_sig));

  exhaustive_stim_misr u_full (
    .clk(clk), .rst_n(rst_n), .start(f_start), .abort(f_abort), .resp(f_resp),
    .stim(f_stim), .vec_count(f_vc), .capture_stb(f_stb), .busy(f_busy),
    .done(f_done), .signature(f_sig));

  function automatic logic [4:0] gate_model(input logic [14:0] s);
    gate_model[0] = ^s;
    gate_model[1] = &s[3:0];
    gate_model[2] = s[14] | s[7];
    gate_model[3] = s[5] ^ (s[9] & s[2]);
    gate_model[4] = |s[14:10];
  endfunction

  assign f_resp = gate_model(f_stim);

  function automatic logic [31:0] exp_stim(input logic [31:0] v);
`ifdef STIM_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  typedef struct {
    logic        stb;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic [1:0]  vc;
  } row_t;

  row_t t2[11];
  row_t t3[6];
  logic        stb_seen;
  int          n;
  logic [15:0] sw;
  logic [14:0] ks;

  initial begin
    // test 2 timeline: SETTLE=1, resp=1, row i sampled after edge E0+i
    t2[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0};
    t2[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0};
    t2[2]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 2'd1};
    t2[3]  = '{1'b0, 16'h0001, 1'b1, 1'b0, 2'd1};
    t2[4]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 2'd2};
    t2[5]  = '{1'b0, 16'h0003, 1'b1, 1'b0, 2'd2};
    t2[6]  = '{1'b1, 16'h0007, 1'b1, 1'b0, 2'd3};
    t2[7]  = '{1'b0, 16'h0007, 1'b1, 1'b0, 2'd3};
    t2[8]  = '{1'b1, 16'h000F, 1'b1, 1'b0, 2'd3};
    t2[9]  = '{1'b0, 16'h000F, 1'b0, 1'b1, 2'd3};
    t2[10] = '{1'b0, 16'h000F, 1'b0, 1'b1, 2'd3};
    // test 3 timeline: SETTLE=0, resp=0
    t3[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0};
    t3[1]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 2'd1};
    t3[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 2'd2};
    t3[3]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 2'd3};
    t3[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 2'd3};
    t3[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd3};

    rst_n = 1'b0;
    s1_start = 0; s1_abort = 0; s1_resp = 5'b00001;
    s0_start = 0; s0_abort = 0; s0_resp = 5'b00000;
    f_start = 0;  f_abort = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // test 1: idle after reset
    stb_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stb_seen = stb_seen | s1_stb | s0_stb | f_stb;
    end
    check("rst_stb_never", 32'(stb_seen), 32'd0);
    check("rst_stim", 32'(f_stim), 32'd0);
    check("rst_vc", 32'(f_vc), 32'd0);
    check("rst_busy", 32'(f_busy), 32'd0);
    check("rst_done", 32'(f_done), 32'd0);
    check("rst_sig", 32'(f_sig), 32'h0000);
    check("rst_s1_sig", 32'(s1_sig), 32'h0000);

    // test 2: SETTLE=1 full run, resp=1
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t2_stb[%0d]", i),  32'(s1_stb),  32'(t2[i].stb));
      check($sformatf("t2_sig[%0d]", i),  32'(s1_sig),  32'(t2[i].sig));
      check($sformatf("t2_busy[%0d]", i), 32'(s1_busy), 32'(t2[i].busy));
      check($sformatf("t2_done[%0d]", i), 32'(s1_done), 32'(t2[i].done));
      check($sformatf("t2_vc[%0d]", i),   32'(s1_vc),   32'(t2[i].vc));
      check($sformatf("t2_stim[%0d]", i), 32'(s1_stim), exp_stim(32'(t2[i].vc)));
    end

    // test 3: SETTLE=0, one vector per cycle
    s0_start = 1'b1;
    @(negedge clk);
    s0_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t3_stb[%0d]", i),  32'(s0_stb),  32'(t3[i].stb));
      check($sformatf("t3_sig[%0d]", i),  32'(s0_sig),  32'(t3[i].sig));
      check($sformatf("t3_busy[%0d]", i), 32'(s0_busy), 32'(t3[i].busy));
      check($sformatf("t3_done[%0d]", i), 32'(s0_done), 32'(t3[i].done));
      check($sformatf("t3_stim[%0d]", i), 32'(s0_stim), exp_stim(32'(t3[i].vc)));
    end

    // test 4: abort on the second capture edge (E0+4)
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_pre_sig", 32'(s1_sig), 32'h0001);
    s1_abort = 1'b1;
    @(negedge clk);
    s1_abort = 1'b0;
    check("t4_sig", 32'(s1_sig), 32'h0001);
    check("t4_busy", 32'(s1_busy), 32'd0);
    check("t4_done", 32'(s1_done), 32'd0);
    check("t4_stim", 32'(s1_stim), 32'd0);
    check("t4_vc", 32'(s1_vc), 32'd0);
    check("t4_stb", 32'(s1_stb), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_idle_busy", 32'(s1_busy), 32'd0);
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    n = 0;
    while (!s1_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_rerun_edges", 32'(n), 32'd9);
    check("t4_rerun_sig", 32'(s1_sig), 32'h000F);

    // test 5: start held high during run, then async reset at E0+3
    s1_start = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("t5_vc_advanced", 32'(s1_vc), 32'd1);
    check("t5_busy", 32'(s1_busy), 32'd1);
    check("t5_sig", 32'(s1_sig), 32'h0001);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_vc", 32'(s1_vc), 32'd0);
    check("t5_rst_stim", 32'(s1_stim), 32'd0);
    check("t5_rst_busy", 32'(s1_busy), 32'd0);
    check("t5_rst_sig", 32'(s1_sig), 32'h0000);
    check("t5_rst_done", 32'(s1_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_restart_busy", 32'(s1_busy), 32'd1);
    check("t5_restart_vc", 32'(s1_vc), 32'd0);
    s1_start = 1'b0;

    // test 6: full default run against software MISR
    sw = 16'h0000;
    for (int k = 0; k < 32768; k++) begin
      ks = 15'(exp_stim(32'(k)));
      sw = {sw[14:0], 1'b0} ^ (sw[15] ? 16'h1021 : 16'h0000) ^ {11'b0, gate_model(ks)};
    end
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    n = 0;
    while (!f_done && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("t6_edges", 32'(n), 32'd65537);
    check("t6_done", 32'(f_done), 32'd1);
    check("t6_busy", 32'(f_busy), 32'd0);
    check("t6_sig", 32'(f_sig), 32'(sw));
    check("t6_vc", 32'(f_vc), 32'h7FFF);
    check("t6_stim", 32'(f_stim), exp_stim(32'h7FFF));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
